// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter
//   Shares one single-port synchronous memory (registered read, one cycle of
//   read latency) between two clients. Whole bursts of 1..4 beats are granted
//   round-robin. The burst address wraps modulo 2**AW.
//
// Handshake: a client raises reqX with weX/addrX/lenX stable. It keeps reqX
//   high until its first ackX. ackX pulses once per beat issued to memory,
//   and the client presents the next wdataX after each ack. Read data comes
//   back one beat per rvalidX, in issue order, one cycle after the matching
//   ackX.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req/we/addr/len/wdataX client X request, direction, start, beats-1, data
//   ackX, rvalidX, rdataX  per-beat ack, read valid, read data (0 unless valid)
//   busy                   high while a multi-beat burst is in progress
//   dbg_state              raw FSM state (0=IDLE, 1=BURST)
//   mem_ren/wen/addr/din   registered memory command
//   mem_dout               memory read data
module mem_burst_arbiter #(
  parameter int AW = 7,
  parameter int DW = 8,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [LW-1:0] len0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [LW-1:0] len1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          ack1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          dbg_state,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state;
  logic          ptr;     // client that wins when both request
  logic          owner;   // client owning the beat now on mem_*
  logic          cool;    // forces one idle memory cycle after a burst
  logic          we_l;
  logic [AW-1:0] addr_l;
  logic [LW-1:0] len_l;
  logic [LW-1:0] cnt;     // index of the next beat to issue

  // Arbitration: a lone requester always wins; on a tie the pointer decides.
  logic          gnt_any;
  logic          gnt_id;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [LW-1:0] g_len;
  logic [DW-1:0] g_wdata;
  logic [DW-1:0] b_wdata;

  always_comb begin
    gnt_any = req0 | req1;
    gnt_id  = (req0 & req1) ? ptr : req1;
    g_we    = gnt_id ? we1    : we0;
    g_addr  = gnt_id ? addr1  : addr0;
    g_len   = gnt_id ? len1   : len0;
    g_wdata = gnt_id ? wdata1 : wdata0;
    b_wdata = owner  ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      cool     <= 1'b0;
      we_l     <= 1'b0;
      addr_l   <= '0;
      len_l    <= '0;
      cnt      <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      mem_ren  <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      mem_ren  <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      // The memory registers dout on the edge after a read beat, so the
      // valid flag is simply the read enable delayed by one cycle, routed
      // to the client that owned that beat.
      rvalid0  <= mem_ren & ~owner;
      rvalid1  <= mem_ren &  owner;

      case (state)
        IDLE: begin
          if (cool) begin
            cool <= 1'b0;
          end else if (gnt_any) begin
            owner    <= gnt_id;
            we_l     <= g_we;
            addr_l   <= g_addr;
            len_l    <= g_len;
            cnt      <= LW'(1);
            mem_addr <= g_addr;
            mem_ren  <= ~g_we;
            mem_wen  <= g_we;
            mem_din  <= g_wdata;
            ack0     <= ~gnt_id;
            ack1     <= gnt_id;
            if (g_len == '0) begin
              ptr  <= ~gnt_id;
              cool <= 1'b1;
              cnt  <= '0;
            end else begin
              state <= BURST;
            end
          end
        end

        BURST: begin
          mem_addr <= addr_l + AW'(cnt);
          mem_ren  <= ~we_l;
          mem_wen  <= we_l;
          mem_din  <= b_wdata;
          ack0     <= ~owner;
          ack1     <= owner;
          cnt      <= cnt + LW'(1);
          if (cnt == len_l) begin
            state <= IDLE;
            ptr   <= ~owner;
            cool  <= 1'b1;
            cnt   <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    dbg_state = state;
    rdata0    = rvalid0 ? mem_dout : '0;
    rdata1    = rvalid1 ? mem_dout : '0;
  end

endmodule
